// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch and data ports.
// Data has priority; fetch is forced through after MAX_WAIT consecutive losses.
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_wen,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int            CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] starve_cnt;
  logic          starve_hit;
  logic          rd_i_p1;
  logic          rd_d_p1;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return {2'b00, byte_addr[XLEN-1:2]};
  endfunction

  assign starve_hit = (starve_cnt == MAX_CNT);
  assign i_gnt      = ~reset & i_req & (~d_req | starve_hit);
  assign d_gnt      = ~reset & d_req & ~(i_req & starve_hit);
  assign mem_en     = i_gnt | d_gnt;
  assign mem_wen    = d_gnt & d_wen;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = word_addr(d_addr);
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = word_addr(i_addr);
    end
  end

  // p0 -> p1: record who owns the read data returning next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      rd_i_p1    <= 1'b0;
      rd_d_p1    <= 1'b0;
    end else begin
      rd_i_p1 <= i_gnt;
      rd_d_p1 <= d_gnt & ~d_wen;
      if (i_gnt || !i_req)
        starve_cnt <= '0;
      else if (d_gnt && !starve_hit)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign i_rvalid = rd_i_p1;
  assign d_rvalid = rd_d_p1;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
